// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction memory boot loader.
// FSM encodings, default geometry and bytes-per-word.
package imem_boot_loader_pkg;

    localparam int INS_ADDRESS_D = 9;
    localparam int INS_W_D       = 32;
    localparam int BYTE_W        = 8;
    localparam int BPW           = INS_W_D / BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte stream valid/ready channel feeding the loader.
// The source drives valid/data, the loader answers with ready.
interface imem_boot_loader_if;
    import imem_boot_loader_pkg::*;

    logic              s_valid;
    logic [BYTE_W-1:0] s_data;
    logic              s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Collects little-endian bytes into one instruction word.
// word_valid pulses the cycle after the last byte of a word lands.
module imem_boot_loader_byte_word_packer
    import imem_boot_loader_pkg::*;
#(
    parameter int INS_W = INS_W_D
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic [INS_W-1:0]  word,
    output logic              word_valid
);

    localparam int NB = INS_W / BYTE_W;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [IW-1:0] byte_idx;
    logic          last_byte;

    assign last_byte = (byte_idx == IW'(NB - 1));

    // Byte lane steering, lane counter and end-of-word strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= in_valid && last_byte && !clear;
            if (clear) begin
                byte_idx <= '0;
            end else if (in_valid) begin
                word[BYTE_W*byte_idx +: BYTE_W] <= in_data;
                byte_idx <= last_byte ? '0 : byte_idx + IW'(1);
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader and read-port arbiter for instruction memory.
// Streams bytes into memory with the core stalled, then hands over to fetch.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int INS_ADDRESS = INS_ADDRESS_D,
    parameter int INS_W       = INS_W_D
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic [INS_ADDRESS-2:0] load_len,
    imem_boot_loader_if.slave      s,
    output logic                   mem_we,
    output logic [INS_ADDRESS-1:0] mem_wa,
    output logic [INS_W-1:0]       mem_wd,
    input  logic [INS_ADDRESS-1:0] pc_addr,
    output logic [INS_ADDRESS-1:0] mem_ra,
    output logic                   core_run,
    output logic                   load_busy,
    output logic                   load_err
);

    localparam int LW    = INS_ADDRESS - 1;
    localparam int DEPTH = 2 ** (INS_ADDRESS - 2);

    state_t           state;
    state_t           state_nx;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    word_cnt;
    logic [LW-1:0]    len_eff;
    logic             len_big;
    logic             start_ok;
    logic             accept;
    logic             last_write;
    logic             word_valid;
    logic [INS_W-1:0] word;

    assign accept     = s.s_valid && s.s_ready;
    assign start_ok   = load_start && (state != ST_LOAD);
    assign len_big    = load_len > LW'(DEPTH);
    assign len_eff    = len_big ? LW'(DEPTH) : load_len;
    assign last_write = mem_we && (word_cnt == len_q - LW'(1));

    imem_boot_loader_byte_word_packer #(
        .INS_W (INS_W)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .in_valid   (accept),
        .in_data    (s.s_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: start from IDLE/RUN, finish after the last word write
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    state_nx = (load_len == '0) ? ST_RUN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_write) begin
                    state_nx = ST_RUN;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Length capture with clamp, write pointer, sticky length error
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q    <= '0;
            word_cnt <= '0;
            load_err <= 1'b0;
        end else if (start_ok) begin
            len_q    <= len_eff;
            word_cnt <= '0;
            load_err <= len_big;
        end else if (mem_we) begin
            word_cnt <= word_cnt + LW'(1);
        end
    end

    // Outputs: handshake, write port and read-port mux
    always_comb begin
        core_run  = (state == ST_RUN);
        load_busy = (state == ST_LOAD);
        s.s_ready = (state == ST_LOAD);
        mem_we    = word_valid && (state == ST_LOAD);
        mem_wd    = word;
        mem_wa    = {word_cnt[INS_ADDRESS-3:0], 2'b00};
        mem_ra    = core_run ? pc_addr : mem_wa;
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader.
// Directed loads; a negedge monitor checks every memory write.
module tb_imem_boot_loader;

    localparam int AW = 9;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [AW-2:0] load_len;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic [AW-1:0] pc_addr;
    logic [AW-1:0] mem_ra;
    logic          core_run;
    logic          load_busy;
    logic          load_err;

    int  total = 0;
    int  bad   = 0;
    int  nwr   = 0;
    wr_t exp_q[$];

    imem_boot_loader_if bus ();

    imem_boot_loader #(
        .INS_ADDRESS (AW),
        .INS_W       (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .s          (bus.slave),
        .mem_we     (mem_we),
        .mem_wa     (mem_wa),
        .mem_wd     (mem_wd),
        .pc_addr    (pc_addr),
        .mem_ra     (mem_ra),
        .core_run   (core_run),
        .load_busy  (load_busy),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int len);
        load_start = 1'b1;
        load_len   = (AW-1)'(len);
        tick();
        load_start = 1'b0;
    endtask

    task automatic push_wr(input int wa, input logic [DW-1:0] wd);
        wr_t e;
        e.wa = AW'(wa);
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1 && n < 3) begin
                bus.s_valid = 1'b0;
                tick();
                n++;
            end
        end
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (!bus.s_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.s_ready) begin
            check("byte_timeout", 64'(n), 64'(0));
        end else begin
            tick();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gaps);
        end
    endtask

    // Write monitor: each pulse must match the next expected write
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            nwr++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got wa=%0h wd=%0h expected none",
                         mem_wa, mem_wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_wa), 64'(e.wa));
                check("wr_data", 64'(mem_wd), 64'(e.wd));
                check("wr_ra_mux", 64'(mem_ra), 64'(e.wa));
            end
        end
    end

    initial begin
        int nwr0;
        logic [DW-1:0] w;
        reset       = 1'b1;
        load_start  = 1'b0;
        load_len    = '0;
        pc_addr     = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("rst_core_run", 64'(core_run), 64'(0));
        check("rst_s_ready", 64'(bus.s_ready), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_ra", 64'(mem_ra), 64'(0));
        check("rst_busy", 64'(load_busy), 64'(0));
        check("rst_err", 64'(load_err), 64'(0));
        check("rst_wd", 64'(mem_wd), 64'(0));

        // Two-word load at full rate
        push_wr(0, 32'h0000_7033);
        push_wr(4, 32'h0010_0093);
        start(2);
        check("ld_busy", 64'(load_busy), 64'(1));
        check("ld_s_ready", 64'(bus.s_ready), 64'(1));
        check("ld_core_run", 64'(core_run), 64'(0));
        send_word(32'h0000_7033, 1'b0);
        check("w0_we", 64'(mem_we), 64'(1));
        check("w0_ready_in_pulse", 64'(bus.s_ready), 64'(1));
        send_word(32'h0010_0093, 1'b0);
        check("w1_we", 64'(mem_we), 64'(1));
        check("w1_core_run_t1", 64'(core_run), 64'(0));
        tick();
        check("run_core_run_t2", 64'(core_run), 64'(1));
        check("run_mem_we", 64'(mem_we), 64'(0));
        check("run_s_ready", 64'(bus.s_ready), 64'(0));
        pc_addr = 9'h1A4;
        #1;
        check("run_mem_ra", 64'(mem_ra), 64'h1A4);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hFF;
        repeat (3) tick();
        check("run_ignore_valid", 64'(bus.s_ready), 64'(0));
        bus.s_valid = 1'b0;

        // Reload from RUN with gaps; a start mid-load is ignored
        push_wr(0, 32'h0000_7033);
        push_wr(4, 32'h0010_0093);
        start(2);
        check("reload_core_run", 64'(core_run), 64'(0));
        check("reload_busy", 64'(load_busy), 64'(1));
        send_word(32'h0000_7033, 1'b1);
        send_byte(8'h93, 1'b1);
        send_byte(8'h00, 1'b1);
        start(5);
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        check("reload_last_we", 64'(mem_we), 64'(1));
        tick();
        check("reload_run", 64'(core_run), 64'(1));

        // Zero-length load goes straight to RUN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("len0_idle", 64'(core_run), 64'(0));
        start(0);
        check("len0_run", 64'(core_run), 64'(1));
        check("len0_busy", 64'(load_busy), 64'(0));
        repeat (3) tick();

        // Oversize length clamps to depth and flags an error
        for (int i = 0; i < 128; i++) begin
            for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(4*i + k);
            push_wr(4*i, w);
        end
        nwr0 = nwr;
        start(200);
        check("big_err", 64'(load_err), 64'(1));
        check("big_busy", 64'(load_busy), 64'(1));
        for (int i = 0; i < 128; i++) begin
            for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(4*i + k);
            send_word(w, 1'b0);
        end
        tick();
        check("big_run", 64'(core_run), 64'(1));
        check("big_writes", 64'(nwr - nwr0), 64'(128));
        check("big_err_hold", 64'(load_err), 64'(1));

        // Reset mid-word discards the partial word
        push_wr(0, 32'hCAFE_F00D);
        start(2);
        check("good_clears_err", 64'(load_err), 64'(0));
        send_word(32'hCAFE_F00D, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_run", 64'(core_run), 64'(0));
        check("mid_rst_busy", 64'(load_busy), 64'(0));
        nwr0 = nwr;
        repeat (5) tick();
        check("mid_rst_no_wr", 64'(nwr - nwr0), 64'(0));
        push_wr(0, 32'h4433_2211);
        start(1);
        send_word(32'h4433_2211, 1'b0);
        check("restart_we", 64'(mem_we), 64'(1));
        check("restart_wa", 64'(mem_wa), 64'(0));
        tick();
        check("restart_run", 64'(core_run), 64'(1));

        push_wr(0, 32'hDEAD_BEEF);
        start(1);
        check("reload2_stall", 64'(core_run), 64'(0));
        send_word(32'hDEAD_BEEF, 1'b1);
        tick();
        check("reload2_run", 64'(core_run), 64'(1));

        repeat (3) tick();
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
